cache_port_arbiter: RTL

//  Shares the single cache port between instruction fetch (I) and the memory stage (D).
//  - Arbitrates between the two requesters and latches the winner's request.
//  - Drives the cache handshake until cache_operation_complete.
//  - Returns data to the winner with a 1-cycle done pulse.
//  - D has priority. A streak limit prevents I starvation. flush cancels an in-flight fetch.

---
 rtl/cache_port_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cache_port_arbiter.sv
// Shares one cache port between instruction fetch (I) and the memory stage (D).
// D has priority, bounded by a contended-grant streak limit; flush cancels fetches.
module cache_port_arbiter #(
  parameter int unsigned ADDR_W       = 64,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_data,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  input  logic              flush,
  output logic              cache_enable,
  output logic              cache_wr_en,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_wr_value,
  input  logic [DATA_W-1:0] cache_data,
  input  logic              cache_operation_complete,
  output logic              busy
);

  localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                kill_q, kill_d;
  logic                if_done_q, if_done_d;
  logic [DATA_W-1:0]   if_data_q, if_data_d;
  logic                dm_done_q, dm_done_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                en_q, en_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wval_q, wval_d;
  logic                busy_q, busy_d;
  logic                i_live;
  logic                d_win;

  // Next-state, arbitration and output-register updates
  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    kill_d     = kill_q;
    if_done_d  = 1'b0;
    dm_done_d  = 1'b0;
    if_data_d  = if_data_q;
    dm_rdata_d = dm_rdata_q;
    en_d       = en_q;
    wr_en_d    = wr_en_q;
    addr_d     = addr_q;
    wval_d     = wval_q;
    // A fetch only contends when it is not being flushed this cycle
    i_live     = if_req && !flush;
    d_win      = dm_req && !(i_live && (streak_q == STREAK_MAX));

    case (state_q)
      IDLE: begin
        if (d_win) begin
          state_d  = GNT_D;
          en_d     = 1'b1;
          wr_en_d  = dm_wr;
          addr_d   = dm_addr;
          wval_d   = dm_wdata;
          streak_d = i_live ? STREAK_W'(streak_q + 1'b1) : '0;
        end else if (i_live) begin
          state_d  = GNT_I;
          en_d     = 1'b1;
          wr_en_d  = 1'b0;
          addr_d   = if_addr;
          wval_d   = '0;
          streak_d = '0;
          kill_d   = 1'b0;
        end
      end
      GNT_I: begin
        if (flush) begin
          kill_d = 1'b1;
        end
        if (cache_operation_complete) begin
          state_d = IDLE;
          en_d    = 1'b0;
          wr_en_d = 1'b0;
          kill_d  = 1'b0;
          // A fetch flushed at any point of its life returns nothing
          if (!(kill_q || flush)) begin
            if_done_d = 1'b1;
            if_data_d = cache_data;
          end
        end
      end
      GNT_D: begin
        if (cache_operation_complete) begin
          state_d   = IDLE;
          en_d      = 1'b0;
          wr_en_d   = 1'b0;
          dm_done_d = 1'b1;
          if (!wr_en_q) begin
            dm_rdata_d = cache_data;
          end
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        wr_en_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      streak_q   <= '0;
      kill_q     <= 1'b0;
      if_done_q  <= 1'b0;
      if_data_q  <= '0;
      dm_done_q  <= 1'b0;
      dm_rdata_q <= '0;
      en_q       <= 1'b0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      wval_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      kill_q     <= kill_d;
      if_done_q  <= if_done_d;
      if_data_q  <= if_data_d;
      dm_done_q  <= dm_done_d;
      dm_rdata_q <= dm_rdata_d;
      en_q       <= en_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      wval_q     <= wval_d;
      busy_q     <= busy_d;
    end
  end

  assign if_done        = if_done_q;
  assign if_data        = if_data_q;
  assign dm_done        = dm_done_q;
  assign dm_rdata       = dm_rdata_q;
  assign cache_enable   = en_q;
  assign cache_wr_en    = wr_en_q;
  assign cache_addr     = addr_q;
  assign cache_wr_value = wval_q;
  assign busy           = busy_q;

endmodule
